// File: rtl/pushbutton_event_ctrl.sv
// Pushbutton sync/debounce/edge-capture Avalon-MM slave with maskable irq.
// Optional PB_PRESS_COUNT_EN: 8-bit button-0 press counter in DATA[15:8].
module pushbutton_event_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } deb_st_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_esel;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_pressed;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;
    logic             w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_pressed = ~r_sync2;
    assign w_unused  = ^writedata[31:WIDTH];

    // Sync stages idle high so a released button reads as not pressed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
        deb_st_t          r_st;
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;

        assign w_deb[gi] = r_db;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_st  <= ST_STABLE;
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else begin
                unique case (r_st)
                    ST_STABLE: begin
                        if (w_pressed[gi] != r_db) begin
                            r_st  <= ST_COUNTING;
                            r_cnt <= CNT_W'(1);
                        end
                    end
                    ST_COUNTING: begin
                        if (w_pressed[gi] == r_db) begin
                            r_st  <= ST_STABLE;
                            r_cnt <= '0;
                        end else if (r_cnt == LP_LAST) begin
                            r_st  <= ST_STABLE;
                            r_cnt <= '0;
                            r_db  <= ~r_db;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_st  <= ST_STABLE;
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign w_rise  = w_deb & ~r_deb_d;
    assign w_fall  = ~w_deb & r_deb_d;
    assign w_event = (w_rise & ~r_esel) | (w_fall & r_esel);
    assign w_clr   = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new event outranks a same-cycle W1C on that bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= '0;
            r_mask  <= '0;
            r_esel  <= '0;
            r_cap   <= '0;
        end else begin
            r_deb_d <= w_deb;
            r_cap   <= (r_cap & ~w_clr) | w_event;
            if (w_wr && address == 2'd1) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            if (w_wr && address == 2'd2) begin
                r_esel <= writedata[WIDTH-1:0];
            end
        end
    end

`ifdef PB_PRESS_COUNT_EN
    logic [7:0] r_pcnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt <= '0;
        end else if (w_wr && address == 2'd0) begin
            r_pcnt <= 8'(w_rise[0]);
        end else begin
            r_pcnt <= r_pcnt + 8'(w_rise[0]);
        end
    end
`endif

    always_comb begin
        w_rd = '0;
        unique case (address)
            2'd0: begin
                w_rd[WIDTH-1:0] = w_deb;
`ifdef PB_PRESS_COUNT_EN
                w_rd[15:8] = r_pcnt;
`endif
            end
            2'd1: w_rd[WIDTH-1:0] = r_mask;
            2'd2: w_rd[WIDTH-1:0] = r_esel;
            2'd3: w_rd[WIDTH-1:0] = r_cap;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd;
        end
    end

    assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_pushbutton_event_ctrl.sv
// Scoreboard bench for pushbutton_event_ctrl, DEBOUNCE_CYCLES=4, WIDTH=4.
// Read requests queue expectations; a negedge monitor checks readdata/irq.
module tb_pushbutton_event_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    pushbutton_event_ctrl #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

`ifdef PB_PRESS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t       q[$];
    logic       rd_req = 1'b0;
    logic       rv = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] m_cnt = 8'h00;

    always @(posedge clk) rv <= rd_req;

    always @(negedge clk) begin
        if (rv) begin
            exp_t e;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL underflow: read with no expectation, readdata=%h", readdata);
            end else begin
                e = q.pop_front();
                n_tests++;
                if (readdata !== e.data) begin
                    n_fail++;
                    $display("FAIL %s: readdata=%h expected %h", e.name, readdata, e.data);
                end
                n_tests++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s_irq: irq=%b expected %b", e.name, irq, e.irq);
                end
            end
        end
    end

    function automatic logic [31:0] dexp(input logic [3:0] deb);
        logic [7:0] c;
        c = CNT_EN ? m_cnt : 8'h00;
        return {16'h0000, c, 4'h0, deb};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] d,
                      input logic ir, input string nm);
        exp_t e;
        e.name = nm;
        e.data = d;
        e.irq  = ir;
        q.push_back(e);
        address = a;
        rd_req  = 1'b1;
        step(1);
        rd_req  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1);
        rd(2'd0, 32'h0, 1'b0, "rst_data");
        rd(2'd1, 32'h0, 1'b0, "rst_mask");
        rd(2'd2, 32'h0, 1'b0, "rst_esel");
        rd(2'd3, 32'h0, 1'b0, "rst_cap");

        // 3-cycle glitch must be rejected
        in_port[0] = 1'b0;
        step(3);
        in_port[0] = 1'b1;
        step(6);
        rd(2'd0, 32'h0, 1'b0, "glitch_data");
        rd(2'd3, 32'h0, 1'b0, "glitch_cap");

        // Press with interrupt, exact latency
        wr(2'd1, 32'h1);
        in_port[0] = 1'b0;
        step(5);
        rd(2'd0, dexp(4'h0), 1'b0, "press_pre");
        rd(2'd0, dexp(4'h1), 1'b1, "press_data");
        m_cnt++;
        rd(2'd3, 32'h1, 1'b1, "press_cap");
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, 1'b0, "w1c_cap");
        rd(2'd0, dexp(4'h1), 1'b0, "press_cnt");
        in_port[0] = 1'b1;
        step(8);
        rd(2'd0, dexp(4'h0), 1'b0, "release0");

        // Release-edge select on button 1
        wr(2'd2, 32'h2);
        in_port[1] = 1'b0;
        step(10);
        rd(2'd3, 32'h0, 1'b0, "rel_after_press");
        rd(2'd0, dexp(4'h2), 1'b0, "rel_data");
        in_port[1] = 1'b1;
        step(10);
        rd(2'd3, 32'h2, 1'b0, "rel_cap");
        wr(2'd1, 32'h3);
        rd(2'd1, 32'h3, 1'b1, "unmask_irq");
        wr(2'd2, 32'h0);
        rd(2'd3, 32'h2, 1'b1, "esel_keep");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h0, 1'b0, "rel_clr");

        // W1C lands in the same cycle as button 2 press event
        in_port[2] = 1'b0;
        step(6);
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h4, 1'b0, "collide_cap");
        rd(2'd0, dexp(4'h4), 1'b0, "collide_data");
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h0, 1'b0, "collide_clr");
        in_port[2] = 1'b1;
        step(10);

        // Press counter wrap
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h0);
        m_cnt = 8'h00;
        for (int i = 0; i < 257; i++) begin
            in_port[0] = 1'b0;
            step(8);
            in_port[0] = 1'b1;
            step(8);
            m_cnt++;
        end
        rd(2'd0, dexp(4'h0), 1'b0, "cnt_wrap");
        rd(2'd3, 32'h1, 1'b0, "cnt_cap");
        wr(2'd3, 32'h1);
        wr(2'd0, 32'h0);
        m_cnt = 8'h00;
        rd(2'd0, dexp(4'h0), 1'b0, "cnt_clear");

        // Press event in the same cycle as counter clear
        in_port[0] = 1'b0;
        step(6);
        wr(2'd0, 32'h0);
        m_cnt = 8'h01;
        rd(2'd0, dexp(4'h1), 1'b0, "cnt_clr_collide");
        in_port[0] = 1'b1;
        step(10);

        // Reset during a count
        wr(2'd1, 32'hF);
        in_port[3] = 1'b0;
        step(4);
        reset_n = 1'b0;
        #2;
        in_port[3] = 1'b1;
        step(1);
        reset_n = 1'b1;
        m_cnt = 8'h00;
        step(1);
        rd(2'd0, 32'h0, 1'b0, "rst2_data");
        rd(2'd1, 32'h0, 1'b0, "rst2_mask");
        step(10);
        rd(2'd3, 32'h0, 1'b0, "no_spurious");

        step(3);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
